addsub_scheduler: RTL and testbench
===================================

Name: addsub_scheduler

Overview:
- Shares one 8-bit two's-complement negate/add datapath (`sign_changer` followed by `add_eight`) between two requesters.
- Round-robin arbitration; valid/ready handshake on the request and result sides.
- Sequences each operation through NEG and ADD phases and reports the 8-bit result, an exact signed-overflow flag and the requester ID.
- Sits between the front-end operand sources and the display/accumulate logic.

Parameters:
- WIDTH, 8, operand/result width; only 8 supported (matches `add_eight`).
- NREQ, 2, number of requesters; only 2 supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-requester request valid
- req_ready_o  out  2  per-requester accept; one-hot or zero
- req_a0_i  in  8  requester 0 operand A (signed)
- req_b0_i  in  8  requester 0 operand B (signed)
- req_sub0_i  in  1  requester 0: 1 = A-B, 0 = A+B
- req_a1_i  in  8  requester 1 operand A
- req_b1_i  in  8  requester 1 operand B
- req_sub1_i  in  1  requester 1 op select
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumer ready
- res_data_o  out  8  result (signed)
- res_ovfl_o  out  1  exact signed overflow
- res_id_o  out  1  ID of the requester that owns the result

Behaviour:
- One clock. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, last_gnt=1 (so requester 0 wins first).
  - res_valid_o=0, res_data_o=0, res_ovfl_o=0, res_id_o=0; internal operand registers 0.
- FSM IDLE -> NEG -> ADD -> DONE -> IDLE.
- IDLE:
  - gnt = the valid requester; if both are valid, the one != last_gnt.
  - req_ready_o = gnt when state==IDLE, else 0 (combinational).
  - Accept edge = req_valid_i[i] & req_ready_o[i]. On it: latch A, B, sub, id; set last_gnt=id; go NEG.
  - No valid requester: stay IDLE.
- NEG:
  - B' = sub ? (~B + 1) : B, via the `sign_changer` path.
  - Register B'; register negovf = sub & (B==8'h80). Go ADD.
- ADD:
  - sum = A + B' mod 256 (`add_eight`, cin=0).
  - ovfl = (A[7]==Beff[7]) & (sum[7]!=A[7]), where Beff is the mathematical sign of ±B. For negovf=1, Beff is treated as positive: ovfl = ~A[7].
  - ovfl equals "exact result outside [-128,127]".
  - Register res_data_o, res_ovfl_o, res_id_o; set res_valid_o=1; go DONE.
- DONE:
  - Hold all res_* outputs stable while res_valid_o & ~res_ready_i.
  - On res_valid_o & res_ready_i: clear res_valid_o and go IDLE. res_data/ovfl/id keep their last values.
- Latency: res_valid_o rises 3 edges after the accept edge.
- Throughput: max one op per 4 cycles; no accept during NEG/ADD/DONE.
- Operand stability: inputs are sampled only on the accept edge. A requester may change or drop valid at any time without affecting an in-flight op.
- Simultaneous requests: alternate strictly while both stay valid (0,1,0,1,...).
- Single requester: served every time; last_gnt still updates.
- Reset mid-operation: immediate return to reset values; in-flight op discarded, no result produced.
- Boundaries:
  - 0-(-128) -> 8'h80, ovfl=1.
  - -1-(-128) -> 8'h7F, ovfl=0.
  - 127+1 -> 8'h80, ovfl=1.
  - -128+(-1) -> 8'h7F, ovfl=1.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when ovfl=1, res_data_o clamps to 8'h7F for positive true results and 8'h80 for negative true results (sign taken from Beff/A, which share a sign whenever ovfl=1). res_ovfl_o still reports 1.
- Undefined: wrap-around result (mod 256); no clamp logic synthesized.

Decomposition:
- Package addsub_pkg:
  - state enum {IDLE, NEG, ADD, DONE} as 2-bit localparams.
  - WIDTH=8; constants MAX_POS=8'h7F, MIN_NEG=8'h80.
  - OP_ADD=0, OP_SUB=1.
- One sub-module: rr_arbiter2 (inputs valid[1:0], last_gnt; output gnt[1:0]), purely combinational.
- Datapath instances `sign_changer` and `add_eight` are reused unchanged inside the block.

Test Plan:
- Reset, then req0 valid with A=5, B=3, sub=1 -> ready0 pulses once; res_valid 3 edges later; data=8'h02, ovfl=0, id=0.
- Both valid continuously, each computing 10+20, res_ready=1 -> ids in order 0,1,0,1; each data=8'h1E; one result per 4 cycles.
- A=0, B=8'h80, sub=1 -> data=8'h80, ovfl=1. With ADDSUB_SATURATE_EN: data=8'h7F, ovfl=1.
- A=8'h7F, B=1, sub=0 -> data=8'h80, ovfl=1 (saturated build: 8'h7F). A=8'hFF, B=8'h80, sub=1 -> data=8'h7F, ovfl=0.
- res_ready=0 for 5 cycles after res_valid -> outputs held; req_ready stays 0 despite pending valids. Raise res_ready -> IDLE on the next edge; next grant goes to the other requester.
- Assert rst_n=0 during ADD -> res_valid=0 immediately; no result after release; last_gnt=1, so req0 wins next.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub scheduler.
package addsub_pkg;

    localparam int unsigned Width = 8;

    localparam logic [7:0] MaxPos = 8'h7F;
    localparam logic [7:0] MinNeg = 8'h80;

    localparam logic OpAdd = 1'b0;
    localparam logic OpSub = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StNeg  = 2'd1,
        StAdd  = 2'd2,
        StDone = 2'd3
    } state_e;

    // Clamp value for an overflowed result whose true sign is 'neg'.
    function automatic logic [7:0] sat_value(input logic neg);
        return neg ? MinNeg : MaxPos;
    endfunction

endpackage

// File: rtl/add_eight.sv
// 8-bit adder with carry-in, result taken mod 256.
module add_eight (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o
);

    // Plain modular sum.
    always_comb begin
        sum_o = a_i + b_i + {7'd0, cin_i};
    end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        gnt_o = 2'b00;
        case (valid_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_gnt_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sign_changer.sv
// 8-bit two's-complement conditional negation.
module sign_changer (
    input  logic [7:0] b_i,
    input  logic       neg_i,
    output logic [7:0] y_o
);

    // Pass through or negate (~b + 1); -128 maps to itself.
    always_comb begin
        y_o = b_i;
        if (neg_i) y_o = ~b_i + 8'd1;
    end

endmodule

// File: rtl/addsub_scheduler.sv
// Shares one negate/add datapath between two requesters using round-robin
// arbitration. Each op runs IDLE -> NEG -> ADD -> DONE.
// Optional: define ADDSUB_SATURATE_EN to clamp overflowed results.
module addsub_scheduler
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = Width,
    parameter int unsigned NREQ  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid_i,
    output logic [NREQ-1:0]  req_ready_o,
    input  logic [WIDTH-1:0] req_a0_i,
    input  logic [WIDTH-1:0] req_b0_i,
    input  logic             req_sub0_i,
    input  logic [WIDTH-1:0] req_a1_i,
    input  logic [WIDTH-1:0] req_b1_i,
    input  logic             req_sub1_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_ovfl_o,
    output logic             res_id_o
);

    state_e state_q, state_d;

    logic [7:0] a_q, b_q, bp_q;
    logic       sub_q, id_q, negovf_q, last_gnt_q;

    logic       res_valid_q, res_ovfl_q, res_id_q;
    logic [7:0] res_data_q;

    logic [1:0] gnt;
    logic       accept;
    logic       sel_id;
    logic [7:0] bneg;
    logic [7:0] sum;
    logic       beff_sign;
    logic       ovfl;
    logic [7:0] result;

    rr_arbiter2 u_arb (
        .valid_i    (req_valid_i),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt)
    );

    sign_changer u_neg (
        .b_i   (b_q),
        .neg_i (sub_q == OpSub),
        .y_o   (bneg)
    );

    add_eight u_add (
        .a_i   (a_q),
        .b_i   (bp_q),
        .cin_i (1'b0),
        .sum_o (sum)
    );

    // Grants are only offered while idle; accept when the granted requester is valid.
    always_comb begin
        req_ready_o = '0;
        if (state_q == StIdle) req_ready_o = gnt;
        accept = |(req_valid_i & req_ready_o);
        sel_id = gnt[1];
    end

    // Exact signed overflow; a negated -128 is mathematically +128 (positive).
    always_comb begin
        beff_sign = negovf_q ? 1'b0 : bp_q[7];
        ovfl      = (a_q[7] == beff_sign) && (sum[7] != a_q[7]);
`ifdef ADDSUB_SATURATE_EN
        result    = ovfl ? sat_value(a_q[7]) : sum;
`else
        result    = sum;
`endif
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StNeg;
            StNeg:  state_d = StAdd;
            StAdd:  state_d = StDone;
            StDone: if (res_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Operand capture on accept, negation stage in NEG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= OpAdd;
            id_q       <= 1'b0;
            last_gnt_q <= 1'b1;
            bp_q       <= '0;
            negovf_q   <= 1'b0;
        end else begin
            if (state_q == StIdle && accept) begin
                a_q        <= sel_id ? req_a1_i : req_a0_i;
                b_q        <= sel_id ? req_b1_i : req_b0_i;
                sub_q      <= sel_id ? req_sub1_i : req_sub0_i;
                id_q       <= sel_id;
                last_gnt_q <= sel_id;
            end
            if (state_q == StNeg) begin
                bp_q     <= bneg;
                negovf_q <= (sub_q == OpSub) && (b_q == MinNeg);
            end
        end
    end

    // Result registers; held in DONE until consumed, values kept afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovfl_q  <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            if (state_q == StAdd) begin
                res_valid_q <= 1'b1;
                res_data_q  <= result;
                res_ovfl_q  <= ovfl;
                res_id_q    <= id_q;
            end else if (state_q == StDone && res_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_ovfl_o  = res_ovfl_q;
    assign res_id_o    = res_id_q;

endmodule

// File: tb/tb_addsub_scheduler.sv
// Directed self-checking bench for addsub_scheduler.
module tb_addsub_scheduler;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a0, req_b0, req_a1, req_b1;
    logic       req_sub0, req_sub1;
    logic       res_valid, res_ready, res_ovfl, res_id;
    logic [7:0] res_data;

    int checks = 0;
    int errors = 0;

    addsub_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a0_i    (req_a0),
        .req_b0_i    (req_b0),
        .req_sub0_i  (req_sub0),
        .req_a1_i    (req_a1),
        .req_b1_i    (req_b1),
        .req_sub1_i  (req_sub1),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_ovfl_o  (res_ovfl),
        .res_id_o    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-requester op with res_ready=1; checks grant, latency and result.
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] ed, input logic eo,
                         input string tag);
        int n;
        logic [1:0] vmask;
        vmask = (id == 0) ? 2'b01 : 2'b10;
        if (id == 0) begin req_a0 = a; req_b0 = b; req_sub0 = sub; end
        else         begin req_a1 = a; req_b1 = b; req_sub1 = sub; end
        req_valid = vmask;
        res_ready = 1'b1;
        #1 chk({tag, "_rdy"}, {14'd0, req_ready}, {14'd0, vmask});
        @(negedge clk);
        req_valid = 2'b00;
        chk({tag, "_rdy_drop"}, {14'd0, req_ready}, 16'd0);
        n = 0;
        while (!res_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n[15:0], 16'd2);
        chk({tag, "_data"}, {8'd0, res_data}, {8'd0, ed});
        chk({tag, "_ovfl"}, {15'd0, res_ovfl}, {15'd0, eo});
        chk({tag, "_id"}, {15'd0, res_id}, id[15:0]);
        @(negedge clk);
    endtask

    initial begin
        int got, cyc, last_cyc, n;
        logic [7:0] exp_sat;

        rst_n = 1'b1; req_valid = 2'b00; res_ready = 1'b1;
        req_a0 = 0; req_b0 = 0; req_sub0 = 0; req_a1 = 0; req_b1 = 0; req_sub1 = 0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_valid", {15'd0, res_valid}, 16'd0);
        chk("rst_data", {8'd0, res_data}, 16'd0);
        chk("rst_ovfl", {15'd0, res_ovfl}, 16'd0);
        chk("rst_id", {15'd0, res_id}, 16'd0);
        chk("rst_ready", {14'd0, req_ready}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic subtract, then boundaries alternating requesters.
        do_op(0, 8'd5, 8'd3, 1'b1, 8'h02, 1'b0, "sub5_3");
`ifdef ADDSUB_SATURATE_EN
        exp_sat = 8'h7F;
`else
        exp_sat = 8'h80;
`endif
        do_op(1, 8'h00, 8'h80, 1'b1, exp_sat, 1'b1, "zero_minus_min");
        do_op(0, 8'h7F, 8'h01, 1'b0, exp_sat, 1'b1, "max_plus_one");
        do_op(1, 8'hFF, 8'h80, 1'b1, 8'h7F, 1'b0, "m1_minus_min");
`ifdef ADDSUB_SATURATE_EN
        exp_sat = 8'h80;
`else
        exp_sat = 8'h7F;
`endif
        do_op(0, 8'h80, 8'hFF, 1'b0, exp_sat, 1'b1, "min_plus_m1");
        do_op(1, 8'h14, 8'h0A, 1'b1, 8'h0A, 1'b0, "sub20_10");

        // Both requesters valid: strict alternation starting with 0, one per 4 cycles.
        req_a0 = 8'd10; req_b0 = 8'd20; req_sub0 = 1'b0;
        req_a1 = 8'd10; req_b1 = 8'd20; req_sub1 = 1'b0;
        req_valid = 2'b11; res_ready = 1'b1;
        got = 0; cyc = 0; last_cyc = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (res_valid) begin
                chk("rr_id", {15'd0, res_id}, {15'd0, got[0]});
                chk("rr_data", {8'd0, res_data}, 16'h1E);
                if (got > 0) chk("rr_gap", cyc[15:0] - last_cyc[15:0], 16'd4);
                last_cyc = cyc;
                got++;
                if (got == 4) req_valid = 2'b00;
            end
        end
        chk("rr_count", got[15:0], 16'd4);
        @(negedge clk);

        // Back-pressure: result held, no grants while blocked.
        req_a0 = 8'd3;  req_b0 = 8'd4; req_sub0 = 1'b0;
        req_a1 = 8'h32; req_b1 = 8'd8; req_sub1 = 1'b1;
        req_valid = 2'b11; res_ready = 1'b0;
        #1 chk("bp_rdy0", {14'd0, req_ready}, 16'h1);
        @(negedge clk);
        n = 0;
        while (!res_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("bp_lat", n[15:0], 16'd2);
        chk("bp_data0", {8'd0, res_data}, 16'h07);
        chk("bp_id0", {15'd0, res_id}, 16'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {15'd0, res_valid}, 16'd1);
            chk("bp_hold_data", {8'd0, res_data}, 16'h07);
            chk("bp_hold_rdy", {14'd0, req_ready}, 16'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {15'd0, res_valid}, 16'd0);
        chk("bp_release_rdy1", {14'd0, req_ready}, 16'h2);
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        while (!res_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("bp_data1", {8'd0, res_data}, 16'h2A);
        chk("bp_id1", {15'd0, res_id}, 16'd1);
        chk("bp_ovfl1", {15'd0, res_ovfl}, 16'd0);
        @(negedge clk);

        // Reset during ADD after serving requester 0: op dropped, requester 0 wins next.
        req_a0 = 8'd1; req_b0 = 8'd1; req_sub0 = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("mid_rst_valid", {15'd0, res_valid}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_result", {15'd0, res_valid}, 16'd0);
        end
        req_valid = 2'b11; res_ready = 1'b0;
        #1 chk("post_rst_gnt0", {14'd0, req_ready}, 16'h1);
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        while (!res_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_data", {8'd0, res_data}, 16'h02);

        // Asynchronous reset while a result is held in DONE.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", {15'd0, res_valid}, 16'd0);
        chk("async_rst_data", {8'd0, res_data}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
